ws281x_chain_ctl: RTL and testbench

Parametrised successor to the fixed 24-bit, 64-entry WS2812 frame controller. It holds a linked list of pixel words in an internal dual-port RAM and serialises one frame on request: each entry's pixel bits go MSB first, one bit per handshake with the downstream bit-waveform encoder. After the frame it emits the latch/reset gap. Compared with the previous generation it adds:

- configurable pixel width (RGB or RGBW), RAM depth, start address and reset gap;
- a runaway-list guard;
- queuing of one pending frame request;
- busy and frame-done status outputs.

---
 rtl/ws281x_chain_ctl.sv | 155 +++++++++++++++
 tb/tb_ws281x_chain_ctl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws281x_chain_ctl.sv
// ws281x_chain_ctl: walks a linked list of pixel words held in on-chip RAM and serialises one frame, MSB first, then a latch gap.
// Latency: frame request to first bit_rdy_out is 3 cycles; each list hop costs 3 cycles; the latch gap lasts RST_CYCLES cycles.
// Backpressure: one bit per bit_rdy_out/bit_done_in handshake; a request seen while busy is queued as a single pending frame.
module ws281x_chain_ctl #(
    parameter int  PIX_BITS   = 24,
    parameter int  ADDR_W     = 6,
    parameter int  START_ADDR = 0,
    parameter int  RST_CYCLES = 10000,
    localparam int WORD_BYTES = PIX_BITS / 8 + 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  wr_en_in,
    input  logic [ADDR_W-1:0]     wr_addr_in,
    input  logic [WORD_BYTES-1:0] wr_byte_en_in,
    input  logic [7:0]            wr_data_in,
    input  logic                  frame_rdy_in,
    input  logic                  bit_done_in,
    output logic                  bit_rdy_out,
    output logic                  bit_data_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam int                WORD_W   = WORD_BYTES * 8;
    localparam int                SEL_W    = $clog2(PIX_BITS);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(PIX_BITS - 1);
    localparam logic [ADDR_W-1:0] HEAD     = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W:0]   PIX_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0]       RST_LAST = 32'(RST_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD0   = 3'd1;
    localparam logic [2:0] S_RD1   = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    logic [WORD_W-1:0]   r_mem [0:DEPTH-1];
    logic [WORD_W-1:0]   r_rd_word;
    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_next_addr;
    logic [ADDR_W:0]     r_pix_cnt;
    logic [31:0]         r_rst_cnt;
    logic [SEL_W-1:0]    r_bit_sel;
    logic [PIX_BITS-1:0] r_shift;
    logic                r_bit_rdy;
    logic                r_wait;
    logic                r_pending;

    logic [PIX_BITS-1:0] w_pix;
    logic [ADDR_W-1:0]   w_ptr;
    logic                w_unused_ptr_hi;
    logic                w_gap_end;

    assign w_pix           = r_rd_word[PIX_BITS-1:0];
    assign w_ptr           = r_rd_word[WORD_W-8 +: ADDR_W];
    // Pointer lane bits above ADDR_W are stored but carry no meaning.
    assign w_unused_ptr_hi = ^r_rd_word[WORD_W-1 -: 8];
    assign w_gap_end       = (r_state == S_LATCH) && (r_rst_cnt == RST_LAST);

    assign bit_rdy_out    = r_bit_rdy;
    assign bit_data_out   = r_shift[PIX_BITS-1];
    assign busy_out       = (r_state != S_IDLE);
    assign frame_done_out = w_gap_end;

    // RAM: byte-lane writes from the host port, registered read in RD0; read returns pre-write data on a collision.
    always_ff @(posedge clk_in) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (wr_en_in && wr_byte_en_in[b]) begin
                r_mem[wr_addr_in][b*8 +: 8] <= wr_data_in;
            end
        end
        if (r_state == S_RD0) begin
            r_rd_word <= r_mem[r_rd_addr];
        end
    end

    // Frame sequencer: list walk, per-bit handshake, latch gap and the one-deep request queue.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_next_addr <= '0;
            r_pix_cnt   <= '0;
            r_rst_cnt   <= '0;
            r_bit_sel   <= '0;
            r_shift     <= '0;
            r_bit_rdy   <= 1'b0;
            r_wait      <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_bit_rdy <= 1'b0;
            // Any request arriving outside IDLE (including the last LATCH cycle) is merged into pending.
            if ((r_state != S_IDLE) && frame_rdy_in) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_rdy_in || r_pending) begin
                        r_state   <= S_RD0;
                        r_rd_addr <= HEAD;
                        r_pix_cnt <= '0;
                        r_pending <= 1'b0;
                    end
                end
                S_RD0: begin
                    r_state <= S_RD1;
                end
                S_RD1: begin
                    r_shift     <= w_pix;
                    r_next_addr <= w_ptr;
                    r_bit_sel   <= '0;
                    r_pix_cnt   <= r_pix_cnt + 1'b1;
                    r_bit_rdy   <= 1'b1;
                    r_wait      <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    // r_wait makes a done pulse count only once per presented bit.
                    if (r_wait && bit_done_in) begin
                        r_wait <= 1'b0;
                        if (r_bit_sel == SEL_LAST) begin
                            // Runaway guard: a frame never exceeds DEPTH pixels even on a cyclic list.
                            if ((r_next_addr == HEAD) || (r_pix_cnt == PIX_MAX)) begin
                                r_state   <= S_LATCH;
                                r_rst_cnt <= '0;
                            end else begin
                                r_rd_addr <= r_next_addr;
                                r_state   <= S_RD0;
                            end
                        end else begin
                            r_bit_sel <= r_bit_sel + 1'b1;
                            r_shift   <= {r_shift[PIX_BITS-2:0], 1'b0};
                            r_bit_rdy <= 1'b1;
                            r_wait    <= 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    if (w_gap_end) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws281x_chain_ctl.sv
// Bench for ws281x_chain_ctl: default-width instance plus a 32-bit/16-deep instance.
// Expected bit streams are queued when a frame is set up and compared against the collected output.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ws281x_chain_ctl;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;

    logic       wr_en_in = 1'b0;
    logic [5:0] wr_addr_in = '0;
    logic [3:0] wr_byte_en_in = '0;
    logic [7:0] wr_data_in = '0;
    logic       frame_rdy_in = 1'b0;
    logic       bit_done_in = 1'b0;
    logic       bit_rdy_out, bit_data_out, busy_out, frame_done_out;

    logic       b_wr_en = 1'b0;
    logic [3:0] b_wr_addr = '0;
    logic [4:0] b_wr_byte_en = '0;
    logic [7:0] b_wr_data = '0;
    logic       b_frame_rdy = 1'b0;
    logic       b_bit_done = 1'b0;
    logic       b_bit_rdy, b_bit_data, b_busy, b_frame_done;

    int   total = 0;
    int   bad = 0;
    logic q_exp[$];
    logic q_got[$];

    always #5 clk_in = ~clk_in;

    ws281x_chain_ctl #(.PIX_BITS(24), .ADDR_W(6), .START_ADDR(0), .RST_CYCLES(16)) u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_byte_en_in(wr_byte_en_in), .wr_data_in(wr_data_in),
        .frame_rdy_in(frame_rdy_in), .bit_done_in(bit_done_in),
        .bit_rdy_out(bit_rdy_out), .bit_data_out(bit_data_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
    );

    ws281x_chain_ctl #(.PIX_BITS(32), .ADDR_W(4), .START_ADDR(0), .RST_CYCLES(4)) u_dut_w (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .wr_en_in(b_wr_en), .wr_addr_in(b_wr_addr), .wr_byte_en_in(b_wr_byte_en), .wr_data_in(b_wr_data),
        .frame_rdy_in(b_frame_rdy), .bit_done_in(b_bit_done),
        .bit_rdy_out(b_bit_rdy), .bit_data_out(b_bit_data), .busy_out(b_busy), .frame_done_out(b_frame_done)
    );

    task automatic step();
        @(negedge clk_in);
    endtask

    task automatic push_pix(input logic [31:0] p, input int w);
        for (int b = w - 1; b >= 0; b--) q_exp.push_back(p[b]);
    endtask

    task automatic wr_a(input logic [5:0] a, input logic [23:0] p, input logic [5:0] nx);
        for (int b = 0; b < 4; b++) begin
            wr_en_in = 1'b1; wr_addr_in = a; wr_byte_en_in = 4'(1 << b);
            wr_data_in = (b < 3) ? p[b*8 +: 8] : {2'b00, nx};
            step();
        end
        wr_en_in = 1'b0; wr_byte_en_in = '0;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [31:0] p, input logic [3:0] nx);
        for (int b = 0; b < 5; b++) begin
            b_wr_en = 1'b1; b_wr_addr = a; b_wr_byte_en = 5'(1 << b);
            b_wr_data = (b < 4) ? p[b*8 +: 8] : {4'h0, nx};
            step();
        end
        b_wr_en = 1'b0; b_wr_byte_en = '0;
    endtask

    task automatic request_a();
        frame_rdy_in = 1'b1; step(); frame_rdy_in = 1'b0;
    endtask

    // Encoder model: collects each presented bit and answers bit_done dly cycles after bit_rdy.
    task automatic encode_a(input int nbits, input int dly, input int req_at);
        int w;
        for (int i = 0; i < nbits; i++) begin
            w = 0;
            while (bit_rdy_out !== 1'b1 && w < 300) begin step(); w++; end
            total++;
            if (bit_rdy_out !== 1'b1) begin
                bad++; $display("FAIL enc_a_timeout: bit %0d got no bit_rdy_out, want pulse", i); return;
            end
            q_got.push_back(bit_data_out);
            repeat (dly) step();
            bit_done_in = 1'b1;
            if (i == req_at) frame_rdy_in = 1'b1;
            step();
            bit_done_in = 1'b0; frame_rdy_in = 1'b0;
        end
    endtask

    task automatic encode_b(input int nbits, input int dly);
        int w;
        for (int i = 0; i < nbits; i++) begin
            w = 0;
            while (b_bit_rdy !== 1'b1 && w < 300) begin step(); w++; end
            total++;
            if (b_bit_rdy !== 1'b1) begin
                bad++; $display("FAIL enc_b_timeout: bit %0d got no bit_rdy_out, want pulse", i); return;
            end
            q_got.push_back(b_bit_data);
            repeat (dly) step();
            b_bit_done = 1'b1; step(); b_bit_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; step(); step();
        total++; if (bit_rdy_out !== 1'b0)    begin bad++; $display("FAIL rst_bit_rdy: got %b want 0", bit_rdy_out); end
        total++; if (bit_data_out !== 1'b0)   begin bad++; $display("FAIL rst_bit_data: got %b want 0", bit_data_out); end
        total++; if (busy_out !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy_out); end
        total++; if (frame_done_out !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done_out); end
        total++; if (b_busy !== 1'b0)         begin bad++; $display("FAIL rst_busy_w: got %b want 0", b_busy); end
        rst_n_in = 1'b1; step();
    endtask

    task automatic test_chain();
        int n, idx; logic e, g;
        wr_a(6'd0, 24'hA50F3C, 6'd5);
        wr_a(6'd5, 24'h000001, 6'd9);
        wr_a(6'd9, 24'h800000, 6'd0);
        push_pix(32'hA50F3C, 24); push_pix(32'h000001, 24); push_pix(32'h800000, 24);
        frame_rdy_in = 1'b1; step(); frame_rdy_in = 1'b0;
        total++; if (busy_out !== 1'b1)    begin bad++; $display("FAIL chain_rd0_busy: got %b want 1", busy_out); end
        total++; if (bit_rdy_out !== 1'b0) begin bad++; $display("FAIL chain_rd0_rdy: got %b want 0", bit_rdy_out); end
        step(); step();
        total++; if (bit_rdy_out !== 1'b1) begin bad++; $display("FAIL chain_first_latency: bit_rdy got %b want 1", bit_rdy_out); end
        encode_a(72, 3, -1);
        n = 0;
        while (frame_done_out !== 1'b1 && n < 100) begin step(); n++; end
        total++; if (n != 15) begin bad++; $display("FAIL chain_latch_len: frame_done after %0d cycles want 15", n); end
        step();
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL chain_idle: busy got %b want 0", busy_out); end
        total++; if (q_got.size() != 72) begin bad++; $display("FAIL chain_count: got %0d bits want 72", q_got.size()); end
        idx = 0;
        while (q_exp.size() > 0 && q_got.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL chain_bit %0d: got %b want %b", idx, g, e); end
            idx++;
        end
        q_exp.delete(); q_got.delete();
    endtask

    task automatic test_self_loop();
        int n, idx; logic e, g;
        wr_a(6'd0, 24'hFFFFFF, 6'd0);
        push_pix(32'hFFFFFF, 24);
        request_a();
        encode_a(24, 3, -1);
        n = 0;
        while (busy_out === 1'b1 && n < 100) begin step(); n++; end
        total++; if (n != 16) begin bad++; $display("FAIL self_busy_fall: busy low after %0d cycles want 16", n); end
        total++; if (q_got.size() != 24) begin bad++; $display("FAIL self_count: got %0d bits want 24", q_got.size()); end
        idx = 0;
        while (q_exp.size() > 0 && q_got.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL self_bit %0d: got %b want %b", idx, g, e); end
            idx++;
        end
        q_exp.delete(); q_got.delete();
    endtask

    task automatic test_runaway();
        int n, extra, idx; logic e, g;
        wr_a(6'd0, 24'h0F1E2D, 6'd1);
        wr_a(6'd1, 24'h3C4B5A, 6'd2);
        wr_a(6'd2, 24'h697887, 6'd1);
        push_pix(32'h0F1E2D, 24);
        for (int i = 1; i < 64; i++) push_pix((i % 2 == 1) ? 32'h3C4B5A : 32'h697887, 24);
        request_a();
        encode_a(1536, 1, -1);
        n = 0; extra = 0;
        while (busy_out === 1'b1 && n < 100) begin
            step(); n++;
            if (bit_rdy_out === 1'b1) extra++;
        end
        total++; if (n != 16)     begin bad++; $display("FAIL runaway_latch: busy low after %0d cycles want 16", n); end
        total++; if (extra != 0)  begin bad++; $display("FAIL runaway_extra_bits: got %0d want 0", extra); end
        total++; if (q_got.size() != 1536) begin bad++; $display("FAIL runaway_count: got %0d bits want 1536", q_got.size()); end
        idx = 0;
        while (q_exp.size() > 0 && q_got.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL runaway_bit %0d: got %b want %b", idx, g, e); end
            idx++;
        end
        q_exp.delete(); q_got.delete();
    endtask

    task automatic test_pending();
        int n, extra, idx; logic e, g;
        wr_a(6'd0, 24'hC3C3C3, 6'd0);
        repeat (3) push_pix(32'hC3C3C3, 24);
        request_a();
        encode_a(24, 3, 5);
        n = 0;
        while (frame_done_out !== 1'b1 && n < 100) begin
            if (n == 4) frame_rdy_in = 1'b1;
            step(); frame_rdy_in = 1'b0; n++;
        end
        total++; if (frame_done_out !== 1'b1) begin bad++; $display("FAIL pend_done1: frame_done got %b want 1", frame_done_out); end
        step();
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL pend_gap1: busy got %b want 0", busy_out); end
        step();
        total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL pend_restart1: busy got %b want 1", busy_out); end
        encode_a(24, 3, -1);
        n = 0;
        while (frame_done_out !== 1'b1 && n < 100) begin step(); n++; end
        frame_rdy_in = 1'b1; step(); frame_rdy_in = 1'b0;
        total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL pend_gap2: busy got %b want 0", busy_out); end
        step();
        total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL pend_edge_req: busy got %b want 1", busy_out); end
        encode_a(24, 3, -1);
        n = 0;
        while (frame_done_out !== 1'b1 && n < 100) begin step(); n++; end
        step();
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_out === 1'b1 || bit_rdy_out === 1'b1) extra++;
            step();
        end
        total++; if (extra != 0) begin bad++; $display("FAIL pend_no_extra_frame: busy cycles %0d want 0", extra); end
        total++; if (q_got.size() != 72) begin bad++; $display("FAIL pend_count: got %0d bits want 72", q_got.size()); end
        idx = 0;
        while (q_exp.size() > 0 && q_got.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL pend_bit %0d: got %b want %b", idx, g, e); end
            idx++;
        end
        q_exp.delete(); q_got.delete();
    endtask

    task automatic test_wide();
        int n, idx; logic e, g;
        wr_b(4'd0, 32'hDEADBEEF, 4'd0);
        push_pix(32'hDEADBEEF, 32);
        b_frame_rdy = 1'b1; step(); b_frame_rdy = 1'b0;
        // Now in RD0: overwrite the top pixel byte in the same cycle as the read.
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_byte_en = 5'b01000; b_wr_data = 8'h00;
        step();
        b_wr_en = 1'b0; b_wr_byte_en = '0;
        encode_b(32, 2);
        n = 0;
        while (b_busy === 1'b1 && n < 50) begin step(); n++; end
        total++; if (n != 4) begin bad++; $display("FAIL wide_latch: busy low after %0d cycles want 4", n); end
        push_pix(32'h00ADBEEF, 32);
        b_frame_rdy = 1'b1; step(); b_frame_rdy = 1'b0;
        encode_b(32, 1);
        n = 0;
        while (b_busy === 1'b1 && n < 50) begin step(); n++; end
        total++; if (q_got.size() != 64) begin bad++; $display("FAIL wide_count: got %0d bits want 64", q_got.size()); end
        idx = 0;
        while (q_exp.size() > 0 && q_got.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL wide_bit %0d: got %b want %b", idx, g, e); end
            idx++;
        end
        q_exp.delete(); q_got.delete();
    endtask

    task automatic test_reset_mid();
        int n, extra, idx; logic e, g;
        wr_a(6'd0, 24'h9E3779, 6'd7);
        wr_a(6'd7, 24'h123456, 6'd0);
        for (int b = 23; b >= 13; b--) q_exp.push_back((b == 23 || b == 20 || b == 19 || b == 18 || b == 17 || b == 13) ? 1'b1 : 1'b0);
        request_a();
        encode_a(11, 3, -1);
        rst_n_in = 1'b0; #1;
        total++; if (bit_rdy_out !== 1'b0)    begin bad++; $display("FAIL mid_rst_rdy: got %b want 0", bit_rdy_out); end
        total++; if (bit_data_out !== 1'b0)   begin bad++; $display("FAIL mid_rst_data: got %b want 0", bit_data_out); end
        total++; if (busy_out !== 1'b0)       begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy_out); end
        total++; if (frame_done_out !== 1'b0) begin bad++; $display("FAIL mid_rst_done: got %b want 0", frame_done_out); end
        step(); step();
        rst_n_in = 1'b1;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            bit_done_in = (i % 2 == 0);
            step();
            if (busy_out === 1'b1 || bit_rdy_out === 1'b1) extra++;
        end
        bit_done_in = 1'b0;
        total++; if (extra != 0) begin bad++; $display("FAIL mid_idle_quiet: active cycles %0d want 0", extra); end
        push_pix(32'h9E3779, 24); push_pix(32'h123456, 24);
        request_a();
        encode_a(48, 2, -1);
        n = 0;
        while (busy_out === 1'b1 && n < 100) begin step(); n++; end
        total++; if (n != 16) begin bad++; $display("FAIL mid_restart_latch: busy low after %0d cycles want 16", n); end
        total++; if (q_got.size() != 59) begin bad++; $display("FAIL mid_count: got %0d bits want 59", q_got.size()); end
        idx = 0;
        while (q_exp.size() > 0 && q_got.size() > 0) begin
            e = q_exp.pop_front(); g = q_got.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL mid_bit %0d: got %b want %b", idx, g, e); end
            idx++;
        end
        q_exp.delete(); q_got.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        test_reset();
        test_chain();
        test_self_loop();
        test_runaway();
        test_pending();
        test_wide();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
